// File: rtl/ps2_keyboard_receiver_pkg.sv
// Shared constants for the PS/2 keyboard receiver: prefix bytes, frame length,
// event field layout and receiver FSM state encoding.
package ps2_defs;

  localparam logic [7:0] PS2_PREFIX_EXT = 8'hE0;
  localparam logic [7:0] PS2_PREFIX_BRK = 8'hF0;

  localparam int PS2_FRAME_LEN = 11;

  // Queued event: {extended, break, code[7:0]}
  localparam int EVT_W       = 10;
  localparam int EVT_EXT_BIT = 9;
  localparam int EVT_BRK_BIT = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RECEIVE = 2'd1,
    CHECK   = 2'd2
  } ps2_state_e;

  // Frame is stored LSB-first: [0]=start, [8:1]=data, [9]=parity, [10]=stop.
  function automatic logic frame_ok(input logic [PS2_FRAME_LEN-1:0] f);
    return ~f[0] & f[10] & (^f[9:1]);
  endfunction

endpackage

// File: rtl/ps2_keyboard_receiver_fifo.sv
// Small synchronous show-ahead FIFO for completed key events; head entry is
// visible combinationally and reads as zero while the queue is empty.
module ps2_event_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             empty,
  output logic             drop
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wptr;
  logic [AW:0]      rptr;
  logic             full;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wptr == rptr);
  assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign do_pop  = pop & ~empty;
  // A pop in the same cycle frees the slot, so a push into a full queue still lands.
  assign do_push = push & (~full | do_pop);
  assign drop    = push & full & ~do_pop;
  assign rdata   = empty ? '0 : mem[rptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wptr[AW-1:0]] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
    end
  end

endmodule

// File: rtl/ps2_keyboard_receiver.sv
// PS/2 keyboard receiver: pin conditioning, frame deserialiser and checker,
// E0/F0 prefix folding, and a small event queue popped by the ALU.
module ps2_keyboard_receiver
  import ps2_defs::*;
#(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int FIFO_DEPTH     = 4,
  parameter int FIFO_AW        = 2
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             PS2_CLK,
  input  logic             PS2_DATA,
  input  logic             iRead,
  input  logic             iClearErr,
  output logic [EVT_W-1:0] oData,
  output logic             oEmpty,
  output logic             oFrameError,
  output logic             oOverflow
);

  localparam int              TW       = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0]   TO_LAST  = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0]      LAST_BIT = 4'(PS2_FRAME_LEN - 1);

  logic [1:0]            clk_sync, dat_sync;
  logic [FILTER_LEN-1:0] clk_sh, dat_sh;
  logic                  clk_f, dat_f, clk_f_d;
  logic                  fe;

  ps2_state_e               state, state_next;
  logic [3:0]               bitcnt;
  logic [PS2_FRAME_LEN-1:0] shreg;
  logic [TW-1:0]            tocnt;
  logic                     ext_pending, brk_pending;
  logic [7:0]               rx_byte;

  logic frame_start, shift_en, to_clr, to_inc;
  logic frame_err, push, set_ext, set_brk, clr_prefix;
  logic [EVT_W-1:0] evt;
  logic fifo_drop;

  // Lines idle high; the filtered level only moves on a full run of equal samples.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      clk_sync <= '1;
      dat_sync <= '1;
      clk_sh   <= '1;
      dat_sh   <= '1;
      clk_f    <= 1'b1;
      dat_f    <= 1'b1;
      clk_f_d  <= 1'b1;
    end else begin
      clk_sync <= {clk_sync[0], PS2_CLK};
      dat_sync <= {dat_sync[0], PS2_DATA};
      clk_sh   <= {clk_sh[FILTER_LEN-2:0], clk_sync[1]};
      dat_sh   <= {dat_sh[FILTER_LEN-2:0], dat_sync[1]};
      if (&clk_sh)       clk_f <= 1'b1;
      else if (~|clk_sh) clk_f <= 1'b0;
      if (&dat_sh)       dat_f <= 1'b1;
      else if (~|dat_sh) dat_f <= 1'b0;
      clk_f_d <= clk_f;
    end
  end

  assign fe      = clk_f_d & ~clk_f;
  assign rx_byte = shreg[8:1];

  always_comb begin
    state_next  = state;
    frame_start = 1'b0;
    shift_en    = 1'b0;
    to_clr      = 1'b0;
    to_inc      = 1'b0;
    frame_err   = 1'b0;
    push        = 1'b0;
    set_ext     = 1'b0;
    set_brk     = 1'b0;
    clr_prefix  = 1'b0;
    case (state)
      IDLE: begin
        to_clr = 1'b1;
        if (fe) begin
          frame_start = 1'b1;
          state_next  = RECEIVE;
        end
      end
      RECEIVE: begin
        if (fe) begin
          shift_en = 1'b1;
          to_clr   = 1'b1;
          if (bitcnt == LAST_BIT) state_next = CHECK;
        end else if (tocnt == TO_LAST) begin
          frame_err  = 1'b1;
          clr_prefix = 1'b1;
          state_next = IDLE;
        end else begin
          to_inc = 1'b1;
        end
      end
      CHECK: begin
        state_next = IDLE;
        if (!frame_ok(shreg)) begin
          frame_err  = 1'b1;
          clr_prefix = 1'b1;
        end else if (rx_byte == PS2_PREFIX_EXT) begin
          set_ext = 1'b1;
        end else if (rx_byte == PS2_PREFIX_BRK) begin
          set_brk = 1'b1;
        end else begin
          push       = 1'b1;
          clr_prefix = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    evt              = '0;
    evt[EVT_EXT_BIT] = ext_pending;
    evt[EVT_BRK_BIT] = brk_pending;
    evt[7:0]         = rx_byte;
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state       <= IDLE;
      bitcnt      <= '0;
      shreg       <= '0;
      tocnt       <= '0;
      ext_pending <= 1'b0;
      brk_pending <= 1'b0;
      oFrameError <= 1'b0;
      oOverflow   <= 1'b0;
    end else begin
      state <= state_next;
      // Bits arrive LSB-first, so each new bit enters at the top and moves down.
      if (frame_start) begin
        shreg  <= {dat_f, {(PS2_FRAME_LEN-1){1'b0}}};
        bitcnt <= 4'd1;
      end else if (shift_en) begin
        shreg  <= {dat_f, shreg[PS2_FRAME_LEN-1:1]};
        bitcnt <= bitcnt + 4'd1;
      end
      if (to_clr)      tocnt <= '0;
      else if (to_inc) tocnt <= tocnt + 1'b1;
      if (clr_prefix) begin
        ext_pending <= 1'b0;
        brk_pending <= 1'b0;
      end else begin
        if (set_ext) ext_pending <= 1'b1;
        if (set_brk) brk_pending <= 1'b1;
      end
      // A new error in the same cycle as a clear request wins.
      if (frame_err)      oFrameError <= 1'b1;
      else if (iClearErr) oFrameError <= 1'b0;
      if (fifo_drop)      oOverflow <= 1'b1;
      else if (iClearErr) oOverflow <= 1'b0;
    end
  end

  ps2_event_fifo #(
    .WIDTH (EVT_W),
    .DEPTH (FIFO_DEPTH),
    .AW    (FIFO_AW)
  ) u_fifo (
    .clk   (Clock),
    .rst_n (Reset),
    .push  (push),
    .pop   (iRead),
    .wdata (evt),
    .rdata (oData),
    .empty (oEmpty),
    .drop  (fifo_drop)
  );

endmodule

// File: tb/tb_ps2_keyboard_receiver.sv
// Bench for ps2_keyboard_receiver: vector table, hand-written corner sequences
// and random frames checked against a queue-based key-event model.
module tb_ps2_keyboard_receiver;
  import ps2_defs::*;

  localparam int FL = 8;
  localparam int TO = 1000;

  logic       Clock = 1'b0;
  logic       Reset;
  logic       PS2_CLK;
  logic       PS2_DATA;
  logic       iRead;
  logic       iClearErr;
  logic [9:0] oData;
  logic       oEmpty;
  logic       oFrameError;
  logic       oOverflow;

  int errors = 0;
  int checks = 0;

  // Reference model state: queued events, pending prefixes, sticky flags.
  logic [9:0] exp_q[$];
  logic       m_ext, m_brk, m_err, m_ovf;

  typedef struct {
    logic [7:0] code;
    logic [1:0] fault;
    logic       exp_empty;
    logic [9:0] exp_data;
    logic       exp_err;
  } vec_t;

  vec_t tbl[13];

  always #10 Clock = ~Clock;

  ps2_keyboard_receiver #(
    .FILTER_LEN     (FL),
    .TIMEOUT_CYCLES (TO),
    .FIFO_DEPTH     (4),
    .FIFO_AW        (2)
  ) dut (
    .Clock       (Clock),
    .Reset       (Reset),
    .PS2_CLK     (PS2_CLK),
    .PS2_DATA    (PS2_DATA),
    .iRead       (iRead),
    .iClearErr   (iClearErr),
    .oData       (oData),
    .oEmpty      (oEmpty),
    .oFrameError (oFrameError),
    .oOverflow   (oOverflow)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge Clock);
    #1;
  endtask

  // fault: 0 none, 1 flipped parity, 2 stop bit low, 3 start bit high
  function automatic logic [10:0] make_frame(input logic [7:0] code, input logic [1:0] fault);
    logic [10:0] f;
    f = {1'b1, ~^code, code, 1'b0};
    case (fault)
      2'd1: f[9]  = ~f[9];
      2'd2: f[10] = 1'b0;
      2'd3: f[0]  = 1'b1;
      default: ;
    endcase
    return f;
  endfunction

  task automatic drive_bit(input logic b, input int half);
    PS2_DATA = b;
    cyc(half);
    PS2_CLK = 1'b0;
    cyc(half);
    PS2_CLK = 1'b1;
  endtask

  task automatic send_bits(input logic [10:0] f, input int nbits, input int half);
    for (int i = 0; i < nbits; i++) drive_bit(f[i], half);
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_ext = 1'b0;
    m_brk = 1'b0;
    m_err = 1'b0;
    m_ovf = 1'b0;
  endtask

  task automatic model_byte(input logic [7:0] code, input logic good);
    if (!good) begin
      m_err = 1'b1;
      m_ext = 1'b0;
      m_brk = 1'b0;
    end else if (code == 8'hE0) begin
      m_ext = 1'b1;
    end else if (code == 8'hF0) begin
      m_brk = 1'b1;
    end else begin
      if (exp_q.size() < 4) exp_q.push_back({m_ext, m_brk, code});
      else m_ovf = 1'b1;
      m_ext = 1'b0;
      m_brk = 1'b0;
    end
  endtask

  task automatic send_frame(input logic [7:0] code, input logic [1:0] fault, input int half);
    send_bits(make_frame(code, fault), 11, half);
    cyc(16);
    model_byte(code, fault == 2'd0);
  endtask

  task automatic check_state(input string tag);
    @(negedge Clock);
    check({tag, "_empty"}, oEmpty, exp_q.size() == 0);
    if (exp_q.size() > 0) check({tag, "_data"}, oData, exp_q[0]);
    check({tag, "_ferr"}, oFrameError, m_err);
    check({tag, "_ovf"}, oOverflow, m_ovf);
  endtask

  task automatic pop_one();
    @(negedge Clock);
    check("pop_data", oData, exp_q[0]);
    @(posedge Clock);
    #1 iRead = 1'b1;
    cyc(1);
    iRead = 1'b0;
    void'(exp_q.pop_front());
  endtask

  task automatic clear_err();
    @(posedge Clock);
    #1 iClearErr = 1'b1;
    cyc(1);
    iClearErr = 1'b0;
    m_err = 1'b0;
    m_ovf = 1'b0;
  endtask

  initial begin
    #4000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [10:0] f;
    int          lat;
    logic        bad;
    logic [7:0]  code;
    logic [1:0]  fault;

    tbl[0]  = '{8'h1C, 2'd0, 1'b0, 10'h01C, 1'b0};
    tbl[1]  = '{8'hF0, 2'd0, 1'b1, 10'h000, 1'b0};
    tbl[2]  = '{8'h1C, 2'd0, 1'b0, 10'h11C, 1'b0};
    tbl[3]  = '{8'hE0, 2'd0, 1'b1, 10'h000, 1'b0};
    tbl[4]  = '{8'hF0, 2'd0, 1'b1, 10'h000, 1'b0};
    tbl[5]  = '{8'h75, 2'd0, 1'b0, 10'h375, 1'b0};
    tbl[6]  = '{8'h1C, 2'd1, 1'b1, 10'h000, 1'b1};
    tbl[7]  = '{8'h1C, 2'd0, 1'b0, 10'h01C, 1'b0};
    tbl[8]  = '{8'hE0, 2'd0, 1'b1, 10'h000, 1'b0};
    tbl[9]  = '{8'h6B, 2'd0, 1'b0, 10'h26B, 1'b0};
    tbl[10] = '{8'hE0, 2'd0, 1'b1, 10'h000, 1'b0};
    tbl[11] = '{8'h1C, 2'd2, 1'b1, 10'h000, 1'b1};
    tbl[12] = '{8'h1C, 2'd0, 1'b0, 10'h01C, 1'b0};

    Reset = 1'b0; PS2_CLK = 1'b1; PS2_DATA = 1'b1; iRead = 1'b0; iClearErr = 1'b0;
    model_reset();
    cyc(3);
    @(negedge Clock);
    check("rst_empty", oEmpty, 1);
    check("rst_data", oData, 0);
    check("rst_ferr", oFrameError, 0);
    check("rst_ovf", oOverflow, 0);
    Reset = 1'b1;
    cyc(10);

    // Latency: raw stop fall -> 2 sync + FILTER_LEN filter + level reg -> fe,
    // then CHECK, then FIFO write; oEmpty drops on the (FL+5)th edge.
    f = make_frame(8'h1C, 2'd0);
    send_bits(f, 10, 20);
    PS2_DATA = 1'b1;
    cyc(20);
    PS2_CLK = 1'b0;
    lat = 0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge Clock);
      #1;
      if (lat == 0 && !oEmpty) lat = i;
    end
    PS2_CLK = 1'b1;
    cyc(20);
    check("latency", lat, FL + 5);
    model_byte(8'h1C, 1'b1);
    check_state("t1");
    pop_one();
    check_state("t1_pop");

    for (int i = 0; i < 13; i++) begin
      send_frame(tbl[i].code, tbl[i].fault, 20);
      @(negedge Clock);
      check($sformatf("tbl%0d_empty", i), oEmpty, tbl[i].exp_empty);
      check($sformatf("tbl%0d_ferr", i), oFrameError, tbl[i].exp_err);
      if (!tbl[i].exp_empty) begin
        check($sformatf("tbl%0d_data", i), oData, tbl[i].exp_data);
        pop_one();
      end
      if (tbl[i].exp_err) clear_err();
    end
    check_state("tbl_end");

    // Short low pulses on the clock pin must never start a frame.
    for (int len = 5; len < FL; len += 2) begin
      bad = 1'b0;
      for (int i = 0; i < 30; i++) begin
        if (i == 0) PS2_CLK = 1'b0;
        if (i == len) PS2_CLK = 1'b1;
        cyc(1);
        if (dut.state != IDLE || dut.fe) bad = 1'b1;
      end
      check($sformatf("glitch%0d", len), bad, 0);
    end
    send_frame(8'h1C, 2'd0, 20);
    check_state("post_glitch");
    pop_one();

    // Abandoned frame after a break prefix: timeout clears the prefix.
    send_frame(8'hF0, 2'd0, 20);
    send_bits(make_frame(8'h29, 2'd0), 5, 20);
    cyc(TO / 2);
    @(negedge Clock);
    check("to_early_state", dut.state == RECEIVE, 1);
    check("to_early_ferr", oFrameError, 0);
    cyc(TO);
    @(negedge Clock);
    check("to_state", dut.state == IDLE, 1);
    m_err = 1'b1; m_ext = 1'b0; m_brk = 1'b0;
    check_state("timeout");
    clear_err();
    send_frame(8'h29, 2'd0, 20);
    check_state("after_to");
    check("after_to_code", oData, 10'h029);
    pop_one();

    // Overflow: five codes, no reads.
    send_frame(8'h16, 2'd0, 15);
    send_frame(8'h1E, 2'd0, 15);
    send_frame(8'h26, 2'd0, 15);
    send_frame(8'h25, 2'd0, 15);
    send_frame(8'h2E, 2'd0, 15);
    check_state("ovf");
    check("ovf_flag", oOverflow, 1);
    clear_err();
    check_state("ovf_clr");
    // Push of 0x36 into the full queue with iRead high in the write cycle.
    f = make_frame(8'h36, 2'd0);
    send_bits(f, 10, 20);
    PS2_DATA = 1'b1;
    cyc(20);
    PS2_CLK = 1'b0;
    cyc(FL + 4);
    iRead = 1'b1;
    cyc(1);
    iRead = 1'b0;
    cyc(20);
    PS2_CLK = 1'b1;
    cyc(16);
    void'(exp_q.pop_front());
    exp_q.push_back(10'h036);
    check_state("ovf_same");
    for (int i = 0; i < 4; i++) pop_one();
    check_state("ovf_drained");

    // Reset mid-frame with a queued entry, an error and a pending prefix.
    send_frame(8'h1C, 2'd0, 20);
    send_frame(8'h1C, 2'd1, 20);
    send_frame(8'hF0, 2'd0, 20);
    check_state("pre_rst");
    send_bits(make_frame(8'h45, 2'd0), 6, 20);
    Reset = 1'b0;
    cyc(1);
    Reset = 1'b1;
    model_reset();
    @(negedge Clock);
    check("mrst_empty", oEmpty, 1);
    check("mrst_data", oData, 0);
    check("mrst_ferr", oFrameError, 0);
    check("mrst_ovf", oOverflow, 0);
    check("mrst_state", dut.state == IDLE, 1);
    cyc(10);
    send_frame(8'h45, 2'd0, 20);
    check_state("after_rst");
    check("after_rst_code", oData, 10'h045);
    pop_one();

    // Random frames, prefixes, faults, reads and clears.
    for (int n = 0; n < 30; n++) begin
      case ($urandom_range(0, 9))
        0: code = 8'hE0;
        1: code = 8'hF0;
        default: code = 8'($urandom_range(0, 255));
      endcase
      fault = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
      send_frame(code, fault, $urandom_range(FL + 2, 25));
      check_state("rnd");
      if (exp_q.size() > 0 && $urandom_range(0, 2) == 0) pop_one();
      if ((m_err || m_ovf) && $urandom_range(0, 3) == 0) clear_err();
    end
    while (exp_q.size() > 0) pop_one();
    check_state("final");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
